// File: rtl/ysyx_23060124_lsu_axi_bridge_pkg.sv
// Shared size codes, bus response codes and FSM encoding for the LSU-to-AXI4-Lite bridge.
package ysyx_23060124_lsu_axi_bridge_pkg;

  localparam logic [1:0] LSU_SZ_B      = 2'b00;
  localparam logic [1:0] LSU_SZ_H      = 2'b01;
  localparam logic [1:0] LSU_SZ_W      = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR   = 3'd3,
    ST_WR_B = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Byte-lane mask of an access at lane 0; the illegal size code yields no lanes.
  function automatic logic [3:0] size_strb(input logic [1:0] size);
    case (size)
      LSU_SZ_B: size_strb = 4'b0001;
      LSU_SZ_H: size_strb = 4'b0011;
      LSU_SZ_W: size_strb = 4'b1111;
      default:  size_strb = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060124_lsu_axi_bridge_if.sv
// LSU request/response channel and AXI4-Lite channel bundles used by the bridge.
interface ysyx_23060124_lsu_axi_bridge_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ren;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_ren, req_wen, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, req_wdata, req_ren, req_wen, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface ysyx_23060124_lsu_axi_bridge_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060124_lsu_axi_bridge_lane_align.sv
// Byte-lane steering between right-aligned LSU data and the 32-bit bus, plus alignment check.
module ysyx_23060124_lsu_lane_align
  import ysyx_23060124_lsu_axi_bridge_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [4:0] w_shamt;

  assign w_shamt = {i_off, 3'b000};
  assign o_wdata = i_wdata << w_shamt;
  assign o_rdata = i_rdata >> w_shamt;
  assign o_wstrb = size_strb(i_size) << i_off;

  always_comb begin
    case (i_size)
      LSU_SZ_B: o_misalign = 1'b0;
      LSU_SZ_H: o_misalign = i_off[0];
      LSU_SZ_W: o_misalign = (i_off != 2'b00);
      default:  o_misalign = 1'b1;
    endcase
  end
endmodule

// File: rtl/ysyx_23060124_lsu_axi_bridge.sv
// Runs one LSU load/store at a time as a single AXI4-Lite transaction and returns data/status.
module ysyx_23060124_lsu_axi_bridge
  import ysyx_23060124_lsu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)(
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  ysyx_23060124_lsu_axi_bridge_lsu_if.slave  lsu,
  ysyx_23060124_lsu_axi_bridge_axi_if.master axi
);
  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_off;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_aw_done;
  logic                r_w_done;

  logic [1:0]          w_off;
  logic [3:0]          w_wstrb;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata_al;
  logic                w_misalign;
  logic                w_accept;
  logic                w_illegal;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_fin;
  logic                w_w_fin;

  // While idle the aligner sees the incoming request; afterwards the captured byte offset.
  assign w_off = (r_state == ST_IDLE) ? lsu.req_addr[1:0] : r_off;

  ysyx_23060124_lsu_lane_align u_align (
    .i_off      (w_off),
    .i_size     (lsu.req_size),
    .i_wdata    (lsu.req_wdata),
    .i_rdata    (axi.rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_al),
    .o_misalign (w_misalign)
  );

  assign w_accept  = lsu.req_valid && (r_state == ST_IDLE);
  assign w_illegal = w_misalign || (lsu.req_ren == lsu.req_wen);
  assign w_aw_hs   = axi.awvalid && axi.awready;
  assign w_w_hs    = axi.wvalid && axi.wready;
  assign w_aw_fin  = r_aw_done || w_aw_hs;
  assign w_w_fin   = r_w_done || w_w_hs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_illegal ? ST_RESP : (lsu.req_ren ? ST_RD_A : ST_WR);
      ST_RD_A: if (axi.arready) w_state_next = ST_RD_D;
      ST_RD_D: if (axi.rvalid) w_state_next = ST_RESP;
      ST_WR:   if (w_aw_fin && w_w_fin) w_state_next = ST_WR_B;
      ST_WR_B: if (axi.bvalid) w_state_next = ST_RESP;
      ST_RESP: if (lsu.rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Every valid/ready is a decode of registered state, never of an incoming ready.
  always_comb begin
    lsu.req_ready = (r_state == ST_IDLE);
    lsu.rsp_valid = (r_state == ST_RESP);
    lsu.rsp_rdata = r_rdata;
    lsu.rsp_err   = r_err;
    axi.arvalid   = (r_state == ST_RD_A);
    axi.rready    = (r_state == ST_RD_D);
    axi.awvalid   = (r_state == ST_WR) && !r_aw_done;
    axi.wvalid    = (r_state == ST_WR) && !r_w_done;
    axi.bready    = (r_state == ST_WR_B);
    axi.araddr    = r_addr;
    axi.awaddr    = r_addr;
    axi.wdata     = r_wdata;
    axi.wstrb     = r_wstrb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr    <= '0;
      r_off     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_addr    <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
          r_off     <= lsu.req_addr[1:0];
          r_wdata   <= w_wdata;
          r_wstrb   <= w_wstrb;
          r_rdata   <= '0;
          r_err     <= w_illegal;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        ST_RD_D: if (axi.rvalid) begin
          r_err   <= (axi.rresp != AXI_RESP_OKAY);
          r_rdata <= (axi.rresp == AXI_RESP_OKAY) ? w_rdata_al : '0;
        end
        ST_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        ST_WR_B: if (axi.bvalid) begin
          r_err   <= (axi.bresp != AXI_RESP_OKAY);
          r_rdata <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060124_lsu_axi_bridge.sv
// Bench for the LSU-to-AXI4-Lite bridge: directed scenarios plus randomized traffic vs. a reference model.
module tb_ysyx_23060124_lsu_axi_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060124_lsu_axi_bridge_lsu_if lsu ();
  ysyx_23060124_lsu_axi_bridge_axi_if axi ();

  ysyx_23060124_lsu_axi_bridge dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .lsu     (lsu),
    .axi     (axi)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int txn_id = 0;

  // Observations of the most recent transaction
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, aw_vcyc, w_vcyc, rsp_cyc, unstable, rdy_bad;
  bit          timeout;
  logic [31:0] ob_araddr, ob_awaddr, ob_wdata, ob_rdata;
  logic [3:0]  ob_wstrb;
  logic        ob_err;

  // Reference model, written straight from the access rules
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_legal(input logic [31:0] addr, input logic [1:0] size, input logic ren, input logic wen);
    if (ren == wen) return 1'b0;
    if (size == 2'd3) return 1'b0;
    return (addr % nbytes(size)) == 0;
  endfunction

  task automatic drive_idle();
    lsu.req_valid = 0; lsu.req_addr = 0; lsu.req_wdata = 0; lsu.req_ren = 0;
    lsu.req_wen = 0; lsu.req_size = 0; lsu.rsp_ready = 0;
    axi.arready = 0; axi.rdata = 0; axi.rresp = 0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
  endtask

  // Issues one request and plays the AXI slave plus the LSU response side until the response handshake.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic ren, input logic wen,
                         input logic [1:0] size, input logic [31:0] rdata_v, input logic [1:0] rresp_v,
                         input logic [1:0] bresp_v, input int ar_wait, input int aw_wait, input int w_wait,
                         input int rsp_hold);
    int ar_seen = 0, aw_seen = 0, w_seen = 0, hold = 0;
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0, b_iss = 0, got_rsp = 0, done = 0;
    bit p_arv = 0, p_awv = 0, p_wv = 0;
    logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0;
    logic [3:0]  p_wstrb = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_vcyc = 0; w_vcyc = 0;
    rsp_cyc = -1; unstable = 0; rdy_bad = 0; timeout = 0;
    ob_araddr = 'x; ob_awaddr = 'x; ob_wdata = 'x; ob_wstrb = 'x; ob_rdata = 'x; ob_err = 'x;
    @(negedge clk);
    drive_idle();
    lsu.req_valid = 1; lsu.req_addr = addr; lsu.req_wdata = wdata;
    lsu.req_ren = ren; lsu.req_wen = wen; lsu.req_size = size;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      lsu.req_valid = 0;
      axi.rvalid = r_pend; axi.rdata = r_pend ? rdata_v : 32'h0; axi.rresp = r_pend ? rresp_v : 2'b00;
      if (r_pend && axi.rready) begin r_cnt++; r_pend = 0; end
      axi.arready = axi.arvalid && (ar_seen >= ar_wait);
      if (axi.arvalid) begin
        if (p_arv && axi.araddr !== p_araddr) unstable++;
        ar_seen++;
      end
      if (axi.arvalid && axi.arready) begin ar_cnt++; ob_araddr = axi.araddr; r_pend = 1; end
      p_arv = axi.arvalid; p_araddr = axi.araddr;
      axi.bvalid = b_pend; axi.bresp = b_pend ? bresp_v : 2'b00;
      if (b_pend && axi.bready) begin b_cnt++; b_pend = 0; end
      axi.awready = axi.awvalid && (aw_seen >= aw_wait);
      if (axi.awvalid) begin
        if (p_awv && axi.awaddr !== p_awaddr) unstable++;
        aw_seen++; aw_vcyc++;
      end
      if (axi.awvalid && axi.awready) begin aw_cnt++; ob_awaddr = axi.awaddr; aw_got = 1; end
      p_awv = axi.awvalid; p_awaddr = axi.awaddr;
      axi.wready = axi.wvalid && (w_seen >= w_wait);
      if (axi.wvalid) begin
        if (p_wv && (axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) unstable++;
        w_seen++; w_vcyc++;
      end
      if (axi.wvalid && axi.wready) begin w_cnt++; ob_wdata = axi.wdata; ob_wstrb = axi.wstrb; w_got = 1; end
      p_wv = axi.wvalid; p_wdata = axi.wdata; p_wstrb = axi.wstrb;
      if (aw_got && w_got && !b_iss) begin b_pend = 1; b_iss = 1; end
      if (lsu.rsp_valid === 1'b1) begin
        if (!got_rsp) begin got_rsp = 1; rsp_cyc = cyc; ob_rdata = lsu.rsp_rdata; ob_err = lsu.rsp_err; end
        else if (lsu.rsp_rdata !== ob_rdata || lsu.rsp_err !== ob_err) unstable++;
        if (lsu.req_ready !== 1'b0) rdy_bad++;
        lsu.rsp_ready = (hold >= rsp_hold);
        hold++;
        if (lsu.rsp_ready) done = 1;
      end else begin
        lsu.rsp_ready = 0;
      end
    end
    if (!done) timeout = 1;
    txn_id++;
    $display("txn %0d: addr=%h wdata=%h ren=%0d wen=%0d size=%0d -> rdata=%h err=%0d rsp_cyc=%0d ar=%0d aw=%0d w=%0d b=%0d",
             txn_id, addr, wdata, ren, wen, size, ob_rdata, ob_err, rsp_cyc, ar_cnt, aw_cnt, w_cnt, b_cnt);
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    @(negedge clk);
    total_cnt++; if (lsu.req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", lsu.req_ready); else pass_cnt++;
    total_cnt++; if (lsu.rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b want 0", lsu.rsp_valid); else pass_cnt++;
    total_cnt++; if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0)
      $display("FAIL reset axi valids/readies: got %b want 00000", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}); else pass_cnt++;
    total_cnt++; if ({axi.araddr, axi.awaddr, axi.wdata} !== 96'h0)
      $display("FAIL reset addr/data: got %h %h %h want 0", axi.araddr, axi.awaddr, axi.wdata); else pass_cnt++;
    total_cnt++; if ({axi.wstrb, lsu.rsp_rdata, lsu.rsp_err} !== 37'h0)
      $display("FAIL reset strb/rsp: got %b %h %b want 0", axi.wstrb, lsu.rsp_rdata, lsu.rsp_err); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_load_word();
    run_txn(32'h8000_0004, 32'h0, 1, 0, 2'd2, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0, 0);
    total_cnt++; if (timeout) $display("FAIL load_word timeout: got no response want response"); else pass_cnt++;
    total_cnt++; if (ob_araddr !== 32'h8000_0004) $display("FAIL load_word araddr: got %h want 80000004", ob_araddr); else pass_cnt++;
    total_cnt++; if (ob_rdata !== 32'hDEAD_BEEF) $display("FAIL load_word rdata: got %h want deadbeef", ob_rdata); else pass_cnt++;
    total_cnt++; if (ob_err !== 1'b0) $display("FAIL load_word err: got %b want 0", ob_err); else pass_cnt++;
    total_cnt++; if (rsp_cyc != 3) $display("FAIL load_word latency: got %0d want 3", rsp_cyc); else pass_cnt++;
    total_cnt++; if (ar_cnt != 1 || r_cnt != 1 || aw_cnt != 0 || w_cnt != 0)
      $display("FAIL load_word bus counts: got ar%0d r%0d aw%0d w%0d want 1 1 0 0", ar_cnt, r_cnt, aw_cnt, w_cnt); else pass_cnt++;
  endtask

  task automatic test_store_byte();
    run_txn(32'h8000_0003, 32'h0000_00A5, 0, 1, 2'd0, 32'h0, 2'b00, 2'b00, 0, 3, 0, 0);
    total_cnt++; if (ob_wdata !== 32'hA500_0000) $display("FAIL store_byte wdata: got %h want a5000000", ob_wdata); else pass_cnt++;
    total_cnt++; if (ob_wstrb !== 4'b1000) $display("FAIL store_byte wstrb: got %b want 1000", ob_wstrb); else pass_cnt++;
    total_cnt++; if (ob_awaddr !== 32'h8000_0000) $display("FAIL store_byte awaddr: got %h want 80000000", ob_awaddr); else pass_cnt++;
    total_cnt++; if (w_vcyc != 1 || aw_vcyc != 4) $display("FAIL store_byte valid cycles: got w%0d aw%0d want w1 aw4", w_vcyc, aw_vcyc); else pass_cnt++;
    total_cnt++; if (b_cnt != 1 || ar_cnt != 0) $display("FAIL store_byte handshakes: got b%0d ar%0d want b1 ar0", b_cnt, ar_cnt); else pass_cnt++;
    total_cnt++; if (ob_err !== 1'b0 || ob_rdata !== 32'h0) $display("FAIL store_byte rsp: got err %b rdata %h want 0 0", ob_err, ob_rdata); else pass_cnt++;
    total_cnt++; if (unstable != 0 || timeout) $display("FAIL store_byte stability: got %0d changes timeout %0d want 0 0", unstable, timeout); else pass_cnt++;
  endtask

  task automatic test_load_half();
    run_txn(32'h8000_0006, 32'h0, 1, 0, 2'd1, 32'h1234_5678, 2'b00, 2'b00, 0, 0, 0, 0);
    total_cnt++; if (ob_rdata !== 32'h0000_1234) $display("FAIL load_half rdata: got %h want 00001234", ob_rdata); else pass_cnt++;
    total_cnt++; if (ob_araddr !== 32'h8000_0004) $display("FAIL load_half araddr: got %h want 80000004", ob_araddr); else pass_cnt++;
  endtask

  task automatic test_illegal();
    run_txn(32'h8000_0002, 32'h1111_2222, 0, 1, 2'd2, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0);
    total_cnt++; if (ar_cnt + aw_cnt + w_cnt + aw_vcyc + w_vcyc != 0)
      $display("FAIL illegal bus activity: got ar%0d aw%0d w%0d want none", ar_cnt, aw_cnt, w_cnt); else pass_cnt++;
    total_cnt++; if (ob_err !== 1'b1) $display("FAIL illegal err: got %b want 1", ob_err); else pass_cnt++;
    total_cnt++; if (rsp_cyc != 1) $display("FAIL illegal latency: got %0d want 1", rsp_cyc); else pass_cnt++;
  endtask

  task automatic test_slverr_backpressure();
    run_txn(32'h8000_0020, 32'h0, 1, 0, 2'd2, 32'hCAFE_F00D, 2'b10, 2'b00, 1, 0, 0, 5);
    total_cnt++; if (ob_err !== 1'b1) $display("FAIL slverr err: got %b want 1", ob_err); else pass_cnt++;
    total_cnt++; if (unstable != 0) $display("FAIL slverr rsp stability: got %0d changes want 0", unstable); else pass_cnt++;
    total_cnt++; if (rdy_bad != 0) $display("FAIL slverr req_ready during resp: got %0d high cycles want 0", rdy_bad); else pass_cnt++;
    total_cnt++; if (rsp_cyc != 4 || timeout) $display("FAIL slverr latency: got %0d want 4", rsp_cyc); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    @(negedge clk);
    drive_idle();
    lsu.req_valid = 1; lsu.req_addr = 32'h8000_0010; lsu.req_ren = 1; lsu.req_size = 2'd2;
    @(negedge clk);
    lsu.req_valid = 0;
    axi.arready = 1;
    @(negedge clk);
    axi.arready = 0;
    total_cnt++; if (axi.rready !== 1'b1) $display("FAIL reset_mid reach rd_d: got rready %b want 1", axi.rready); else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total_cnt++; if ({axi.rready, axi.arvalid, lsu.rsp_valid} !== 3'b000)
      $display("FAIL reset_mid outputs: got rready/arvalid/rsp_valid %b want 000", {axi.rready, axi.arvalid, lsu.rsp_valid}); else pass_cnt++;
    total_cnt++; if (lsu.req_ready !== 1'b1) $display("FAIL reset_mid req_ready: got %b want 1", lsu.req_ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    rd = $urandom;
    run_txn(32'h8000_0008, 32'h0, 1, 0, 2'd2, rd, 2'b00, 2'b00, 0, 0, 0, 0);
    total_cnt++; if (ob_rdata !== rd || ob_err !== 1'b0 || rsp_cyc != 3)
      $display("FAIL reset_mid next load: got %h err %b cyc %0d want %h 0 3", ob_rdata, ob_err, rsp_cyc, rd); else pass_cnt++;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] addr, wd, rd, exp_rdata, exp_wdata;
      logic [1:0]  size, rresp, bresp;
      logic [3:0]  exp_strb;
      logic        ren, wen, exp_err;
      bit          legal;
      int          aw_w, w_w, ar_w, hold, op, off, exp_cyc;
      size = 2'($urandom_range(0, 3));
      addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~32'(nbytes(size) - 1);
      op = $urandom_range(0, 9);
      ren = (op == 0) || (op >= 2 && op < 6);
      wen = (op == 0) || (op >= 6);
      wd = $urandom; rd = $urandom;
      rresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ar_w = $urandom_range(0, 3); aw_w = $urandom_range(0, 3); w_w = $urandom_range(0, 3); hold = $urandom_range(0, 3);
      legal = is_legal(addr, size, ren, wen);
      off = addr % 4;
      exp_err = !legal || (ren ? (rresp != 0) : (bresp != 0));
      exp_rdata = (legal && ren && rresp == 0) ? (rd >> (8 * off)) : 32'h0;
      exp_wdata = wd << (8 * off);
      exp_strb = 4'(((1 << nbytes(size)) - 1) << off);
      exp_cyc = !legal ? 1 : ren ? 3 + ar_w : 3 + ((aw_w > w_w) ? aw_w : w_w);
      run_txn(addr, wd, ren, wen, size, rd, rresp, bresp, ar_w, aw_w, w_w, hold);
      total_cnt++; if (timeout || ob_err !== exp_err || ob_rdata !== exp_rdata)
        $display("FAIL random[%0d] rsp: got err %b rdata %h timeout %0d want err %b rdata %h", i, ob_err, ob_rdata, timeout, exp_err, exp_rdata); else pass_cnt++;
      total_cnt++; if (rsp_cyc != exp_cyc) $display("FAIL random[%0d] latency: got %0d want %0d", i, rsp_cyc, exp_cyc); else pass_cnt++;
      total_cnt++; if (ar_cnt != int'(legal && ren) || aw_cnt != int'(legal && wen) || w_cnt != int'(legal && wen) || b_cnt != int'(legal && wen))
        $display("FAIL random[%0d] bus counts: got ar%0d aw%0d w%0d b%0d want ar%0d wr%0d", i, ar_cnt, aw_cnt, w_cnt, b_cnt, legal && ren, legal && wen); else pass_cnt++;
      if (legal && ren) begin
        total_cnt++; if (ob_araddr !== (addr & ~32'h3)) $display("FAIL random[%0d] araddr: got %h want %h", i, ob_araddr, addr & ~32'h3); else pass_cnt++;
      end
      if (legal && wen) begin
        total_cnt++; if (ob_awaddr !== (addr & ~32'h3) || ob_wdata !== exp_wdata || ob_wstrb !== exp_strb)
          $display("FAIL random[%0d] write beat: got %h %h %b want %h %h %b", i, ob_awaddr, ob_wdata, ob_wstrb, addr & ~32'h3, exp_wdata, exp_strb); else pass_cnt++;
      end
      total_cnt++; if (unstable != 0 || rdy_bad != 0)
        $display("FAIL random[%0d] stability: got %0d changes %0d ready cycles want 0 0", i, unstable, rdy_bad); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_load_half();
    test_illegal();
    test_slverr_backpressure();
    test_reset_mid();
    test_random(40);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
